// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_UP = 2'd1,
      RUN_DN = 2'd2
   } sweep_state_t;

   localparam int FWORD_W_DEF = 32;
   localparam int PWORD_W_DEF = 12;
   localparam int DWELL_W_DEF = 24;
   localparam int CLK_HZ      = 50_000_000;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts 0..dwell while enabled and ticks for one cycle at count==dwell.
module dwell_timer
   import dds_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tick
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (en)
         cnt_d = (cnt_q == dwell) ? '0 : cnt_q + DWELL_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = en && !clear && (cnt_q == dwell);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving both DDS channels.
// Define SWEEP_BIDIR_EN for a triangle (up/down) sweep; default is sawtooth only.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int FWORD_W = FWORD_W_DEF,
   parameter int PWORD_W = PWORD_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Mode,
   input  logic [FWORD_W-1:0] Fstart,
   input  logic [FWORD_W-1:0] Fstop,
   input  logic [FWORD_W-1:0] Fstep,
   input  logic [DWELL_W-1:0] Dwell,
   input  logic [PWORD_W-1:0] Pofs,
   output logic [FWORD_W-1:0] Fword1,
   output logic [FWORD_W-1:0] Fword2,
   output logic [PWORD_W-1:0] Pword1,
   output logic [PWORD_W-1:0] Pword2,
   output logic               Busy,
   output logic               Done,
   output logic               Cfg_err
);

   sweep_state_t       state_q, state_d;
   logic [FWORD_W-1:0] fword_q, fword_d;
   logic [FWORD_W-1:0] fstart_q, fstart_d, fstop_q, fstop_d, fstep_q, fstep_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [PWORD_W-1:0] pword2_q, pword2_d;
   logic               mode_q, mode_d;
   logic               busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
   logic               tmr_clr, tick;
   logic [FWORD_W:0]   up_sum;
   logic               up_ok, cfg_bad;

   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk   (Clk),
      .reset (Reset),
      .clear (tmr_clr),
      .en    (state_q != IDLE),
      .dwell (dwell_q),
      .tick  (tick)
   );

   // Extra bit keeps a carry out of the add from looking like a small legal value.
   assign up_sum  = {1'b0, fword_q} + {1'b0, fstep_q};
   assign up_ok   = (up_sum <= {1'b0, fstop_q});
   assign cfg_bad = (Fstep == '0) || (Fstart > Fstop);

`ifdef SWEEP_BIDIR_EN
   logic [FWORD_W:0] dn_diff;
   logic             dn_ok;
   assign dn_diff = {1'b0, fword_q} - {1'b0, fstep_q};
   assign dn_ok   = !dn_diff[FWORD_W] && (dn_diff[FWORD_W-1:0] >= fstart_q);
`endif

   always_comb begin
      state_d   = state_q;
      fword_d   = fword_q;
      fstart_d  = fstart_q;
      fstop_d   = fstop_q;
      fstep_d   = fstep_q;
      dwell_d   = dwell_q;
      mode_d    = mode_q;
      pword2_d  = pword2_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      tmr_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start && !Stop) begin
               if (cfg_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  fstart_d = Fstart;
                  fstop_d  = Fstop;
                  fstep_d  = Fstep;
                  dwell_d  = Dwell;
                  mode_d   = Mode;
                  pword2_d = Pofs;
                  fword_d  = Fstart;
                  busy_d   = 1'b1;
                  tmr_clr  = 1'b1;
                  state_d  = RUN_UP;
               end
            end
         end
         RUN_UP: begin
            if (Stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (tick) begin
               if (up_ok) begin
                  fword_d = up_sum[FWORD_W-1:0];
`ifdef SWEEP_BIDIR_EN
               end else if (dn_ok) begin
                  fword_d = dn_diff[FWORD_W-1:0];
                  state_d = RUN_DN;
`endif
               end else if (mode_q) begin
                  fword_d = fstart_q;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
`ifdef SWEEP_BIDIR_EN
         RUN_DN: begin
            if (Stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (tick) begin
               if (dn_ok) begin
                  fword_d = dn_diff[FWORD_W-1:0];
               end else if (mode_q) begin
                  // Turn around without repeating the bottom value.
                  fword_d = up_ok ? up_sum[FWORD_W-1:0] : fstart_q;
                  state_d = RUN_UP;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         fword_q   <= '0;
         fstart_q  <= '0;
         fstop_q   <= '0;
         fstep_q   <= '0;
         dwell_q   <= '0;
         mode_q    <= 1'b0;
         pword2_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fword_q   <= fword_d;
         fstart_q  <= fstart_d;
         fstop_q   <= fstop_d;
         fstep_q   <= fstep_d;
         dwell_q   <= dwell_d;
         mode_q    <= mode_d;
         pword2_q  <= pword2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign Fword1  = fword_q;
   assign Fword2  = fword_q;
   assign Pword1  = '0;
   assign Pword2  = pword2_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Cfg_err = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a list-based sweep model queues per-cycle expected outputs.
module tb_dds_sweep_ctrl;
   import dds_pkg::*;

   localparam int FW = 32;
   localparam int PW = 12;
   localparam int DW = 24;

   logic          clk, rst, start, stop, mode;
   logic [FW-1:0] fstart, fstop, fstep;
   logic [DW-1:0] dwell;
   logic [PW-1:0] pofs;
   logic [FW-1:0] fword1, fword2;
   logic [PW-1:0] pword1, pword2;
   logic          busy, done, cfg_err;

   typedef struct packed {
      logic [FW-1:0] fw;
      logic [PW-1:0] pw;
      logic          busy;
      logic          done;
      logic          err;
   } rec_t;

   rec_t expq[$];
   rec_t cur;
   int   checks   = 0;
   int   failures = 0;

   dds_sweep_ctrl #(.FWORD_W(FW), .PWORD_W(PW), .DWELL_W(DW)) dut (
      .Clk(clk), .Reset(rst), .Start(start), .Stop(stop), .Mode(mode),
      .Fstart(fstart), .Fstop(fstop), .Fstep(fstep), .Dwell(dwell), .Pofs(pofs),
      .Fword1(fword1), .Fword2(fword2), .Pword1(pword1), .Pword2(pword2),
      .Busy(busy), .Done(done), .Cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one queued record describes the outputs after one clock edge.
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         rec_t e;
         e = expq.pop_front();
         checks++;
         if (fword1 !== e.fw || fword2 !== e.fw || pword1 !== '0 || pword2 !== e.pw ||
             busy !== e.busy || done !== e.done || cfg_err !== e.err) begin
            failures++;
            $display("FAIL outputs t=%0t got fw1=%0d fw2=%0d pw1=%0d pw2=%0d busy=%b done=%b err=%b want fw=%0d pw1=0 pw2=%0d busy=%b done=%b err=%b",
                     $time, fword1, fword2, pword1, pword2, busy, done, cfg_err,
                     e.fw, e.pw, e.busy, e.done, e.err);
         end
      end
   end

   task automatic drain();
      int guard = 0;
      while (expq.size() > 0 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (expq.size() > 0) begin
         failures++;
         $display("FAIL drain timeout left=%0d want 0", expq.size());
         expq.delete();
      end
      @(negedge clk);
   endtask

   // kind: 0 none, 1 Stop, 2 Stop+Start, 3 Reset, 4 Start while busy; applied at edge k+s.
   task automatic scenario(input int kind_in, input int s, input logic [FW-1:0] fs,
                           input logic [FW-1:0] fe, input logic [FW-1:0] st,
                           input int dw, input logic md, input logic [PW-1:0] po);
      logic [63:0]   v;
      logic [FW-1:0] u[$];
      logic [FW-1:0] seq[$];
      rec_t          tr[$];
      rec_t          r;
      int            kind, n, total, len, dw1;
      bit            valid;
      kind  = kind_in;
      valid = (st != 0) && (fs <= fe);
      dw1   = dw + 1;
      total = 0;
      if (!valid) begin
         kind = 0;
         r = '{fw: cur.fw, pw: cur.pw, busy: 1'b0, done: 1'b0, err: 1'b1};
         tr.push_back(r);
         r.err = 1'b0;
         tr.push_back(r);
      end else begin
         v = {32'd0, fs};
         while (v <= {32'd0, fe}) begin
            u.push_back(v[FW-1:0]);
            v = v + {32'd0, st};
         end
         n = u.size();
         foreach (u[i]) seq.push_back(u[i]);
`ifdef SWEEP_BIDIR_EN
         if (!md) for (int i = n - 2; i >= 0; i--) seq.push_back(u[i]);
         else     for (int i = n - 2; i >= 1; i--) seq.push_back(u[i]);
`endif
         if (!md) total = seq.size() * dw1;
         if (md && (kind == 0 || kind == 4)) kind = 1;
         if (kind == 4 && s >= total) kind = 0;
         len = md ? 0 : total + 2;
         if (kind != 0 && s + 2 > len) len = s + 2;
         for (int i = 0; i < len; i++) begin
            if (md)
               r = '{fw: seq[(i / dw1) % seq.size()], pw: po, busy: 1'b1, done: 1'b0, err: 1'b0};
            else if (i < total)
               r = '{fw: seq[i / dw1], pw: po, busy: 1'b1, done: 1'b0, err: 1'b0};
            else
               r = '{fw: seq[seq.size() - 1], pw: po, busy: 1'b0, done: (i == total), err: 1'b0};
            tr.push_back(r);
         end
         for (int i = s; i < len && (kind == 1 || kind == 2 || kind == 3); i++) begin
            if (kind == 3) tr[i] = '0;
            else           tr[i] = '{fw: tr[s - 1].fw, pw: po, busy: 1'b0, done: 1'b0, err: 1'b0};
         end
      end

      @(posedge clk); #1;
      fstart = fs; fstop = fe; fstep = st; dwell = DW'(dw); mode = md; pofs = po;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      // Scramble the inputs: the running sweep must rely on latched values only.
      fstart = $urandom; fstop = $urandom; fstep = $urandom;
      dwell  = DW'($urandom_range(0, 7)); mode = 1'($urandom); pofs = PW'($urandom);
      foreach (tr[i]) expq.push_back(tr[i]);
      if (kind != 0) begin
         for (int i = 1; i < s; i++) begin
            @(posedge clk); #1;
         end
         case (kind)
            1: stop = 1'b1;
            2: begin stop = 1'b1; start = 1'b1; end
            3: rst = 1'b1;
            default: start = 1'b1;
         endcase
         @(posedge clk); #1;
         stop = 1'b0; start = 1'b0; rst = 1'b0;
      end
      drain();
      cur = tr[tr.size() - 1];
   endtask

   initial begin
      logic [FW-1:0] fs, fe, st;
      logic          md;
      int            kd;
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
      fstart = '0; fstop = '0; fstep = '0; dwell = '0; pofs = '0;
      @(posedge clk); #1;
      expq.push_back('0);
      drain();
      rst = 1'b0;
      cur = '0;

      scenario(0, 0, 100, 130, 10, 2, 1'b0, 12'd1024);
      scenario(1, 25, 100, 125, 10, 0, 1'b1, 12'd1024);
      scenario(0, 0, 100, 130, 0, 1, 1'b0, 12'd5);
      scenario(0, 0, 200, 100, 5, 1, 1'b0, 12'd5);
      scenario(0, 0, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 15, 1, 1'b0, 12'd7);
      scenario(2, 5, 100, 130, 10, 2, 1'b0, 12'd300);
      scenario(4, 4, 100, 130, 10, 2, 1'b0, 12'd301);
      scenario(3, 7, 100, 130, 10, 1, 1'b1, 12'd302);
      scenario(1, 30, 100, 130, 10, 1, 1'b1, 12'd1024);
      scenario(0, 0, 50, 50, 3, 1, 1'b0, 12'd9);
      scenario(1, 9, 50, 50, 3, 0, 1'b1, 12'd10);

      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) fs = 32'hFFFF_FFFF - $urandom_range(0, 60);
         else                           fs = $urandom_range(0, 1000);
         st = $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) st = 0;
         if ({32'd0, fs} + 64'($urandom_range(0, 80)) > 64'h0000_0000_FFFF_FFFF)
            fe = 32'hFFFF_FFFF;
         else
            fe = fs + $urandom_range(0, 80);
         if ($urandom_range(0, 9) == 0 && fs > 0) fe = fs - 1;
         md = 1'($urandom_range(0, 1));
         kd = md ? $urandom_range(1, 3) : $urandom_range(0, 4);
         scenario(kd, $urandom_range(1, 40), fs, fe, st, $urandom_range(0, 3), md, PW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
